// File: rtl/tx_serial_pkg.sv
// ----------------------------------------------------------------------------
// tx_serial_pkg
// Shared definitions for the tic-tac-toe status transmitter.
//   - estado_t     : states of the byte serialiser FSM
//   - BYTE_SINC    : sync byte that opens every frame
//   - N_BYTES      : bytes per frame (3, or 4 with the XOR checksum byte)
//   - ULTIMO_RESET : reset value of the "last transmitted status" register
// Build option: TX_JOGO_CHECKSUM_EN adds the checksum byte and its helper.
// ----------------------------------------------------------------------------
package tx_serial_pkg;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        INICIO = 2'd1,
        DADOS  = 2'd2,
        PARADA = 2'd3
    } estado_t;

    localparam logic [7:0]  BYTE_SINC    = 8'hA5;
    localparam logic [15:0] ULTIMO_RESET = 16'hFFFF;

`ifdef TX_JOGO_CHECKSUM_EN
    localparam int N_BYTES = 4;

    function automatic logic [7:0] checksum(input logic [15:0] s);
        return s[15:8] ^ s[7:0];
    endfunction
`else
    localparam int N_BYTES = 3;
`endif

endpackage

// File: rtl/uart_tx_byte.sv
// ----------------------------------------------------------------------------
// uart_tx_byte
// Single-byte 8N1 serialiser: start bit (0), 8 data bits LSB first, stop
// bit (1), each CICLOS_BIT clock cycles long.
// Ports:
//   clock   in   system clock, rising edge
//   reset   in   synchronous, active-high
//   partida in   start request; accepted when idle or in the last cycle of
//                the stop bit, so bytes can be chained with no gap
//   dado    in   byte to send, captured together with partida
//   tx      out  registered serial line, idle high
//   pronto  out  high during the last cycle of the stop bit
// ----------------------------------------------------------------------------
module uart_tx_byte
    import tx_serial_pkg::*;
#(
    parameter int CICLOS_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       partida,
    input  logic [7:0] dado,
    output logic       tx,
    output logic       pronto
);

    localparam int BAUD_W = (CICLOS_BIT > 1) ? $clog2(CICLOS_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_ULT = BAUD_W'(CICLOS_BIT - 1);

    estado_t           estado;
    logic [BAUD_W-1:0] baud;
    logic [2:0]        bit_idx;
    logic [7:0]        desloc;
    logic              fim_bit;

    assign fim_bit = (baud == BAUD_ULT);
    assign pronto  = (estado == PARADA) && fim_bit;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado  <= OCIOSO;
            tx      <= 1'b1;
            baud    <= '0;
            bit_idx <= '0;
            desloc  <= '0;
        end else begin
            case (estado)
                OCIOSO: begin
                    baud <= '0;
                    if (partida) begin
                        desloc <= dado;
                        tx     <= 1'b0;
                        estado <= INICIO;
                    end
                end

                INICIO: begin
                    if (fim_bit) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        tx      <= desloc[0];
                        desloc  <= {1'b1, desloc[7:1]};
                        estado  <= DADOS;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end

                DADOS: begin
                    if (fim_bit) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            tx     <= 1'b1;
                            estado <= PARADA;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= desloc[0];
                            desloc  <= {1'b1, desloc[7:1]};
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end

                PARADA: begin
                    if (fim_bit) begin
                        baud <= '0;
                        // Chained start: the next byte's start bit follows
                        // the stop bit directly.
                        if (partida) begin
                            desloc <= dado;
                            tx     <= 1'b0;
                            estado <= INICIO;
                        end else begin
                            estado <= OCIOSO;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end

                default: begin
                    estado <= OCIOSO;
                    tx     <= 1'b1;
                    baud   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/tx_serial_jogo.sv
// ----------------------------------------------------------------------------
// tx_serial_jogo
// Serial status transmitter for the ultimate tic-tac-toe game. Sends a
// frame {A5, {macro,micro}, {estado,res_macro,res_jogo} [, checksum]} over
// an 8N1 line whenever the status word changes or a resend is requested.
// Changes during a frame are not latched; the latest status wins.
// Build option: TX_JOGO_CHECKSUM_EN adds byte 3 = byte1 XOR byte2.
// Ports:
//   clock                 in   system clock, rising edge
//   reset                 in   synchronous, active-high
//   uart_macro[3:0]       in   current macro board index
//   uart_micro[3:0]       in   current micro cell index
//   uart_estado[3:0]      in   control FSM state code
//   uart_resultado_macro  in   result of current macro board (2 b)
//   uart_resultado_jogo   in   overall game result (2 b)
//   forcar                in   one-cycle resend request
//   tx                    out  serial line, idle high
//   ocupado               out  high while a frame is on the line
//   fim_envio             out  one-cycle pulse after a frame completes
// ----------------------------------------------------------------------------
module tx_serial_jogo
    import tx_serial_pkg::*;
#(
    parameter int CICLOS_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] uart_macro,
    input  logic [3:0] uart_micro,
    input  logic [3:0] uart_estado,
    input  logic [1:0] uart_resultado_macro,
    input  logic [1:0] uart_resultado_jogo,
    input  logic       forcar,
    output logic       tx,
    output logic       ocupado,
    output logic       fim_envio
);

    localparam logic [1:0] IDX_ULT = 2'(N_BYTES - 1);

    logic [15:0] status;
    logic [15:0] ultimo;
    logic [15:0] quadro;
    logic        pendente;
    logic [1:0]  indice;
    logic [1:0]  indice_prox;
    logic        gatilho;
    logic        inicia_quadro;
    logic        proximo_byte;
    logic        partida;
    logic        pronto;
    logic [7:0]  dado;

    assign status = {uart_macro, uart_micro, uart_estado,
                     uart_resultado_macro, uart_resultado_jogo};

    assign gatilho       = (status != ultimo) || pendente || forcar;
    assign inicia_quadro = !ocupado && gatilho;
    assign proximo_byte  = ocupado && pronto && (indice != IDX_ULT);
    assign partida       = inicia_quadro || proximo_byte;
    assign indice_prox   = indice + 2'd1;

    // Byte 0 is the constant sync, so the frame buffer only has to be valid
    // from byte 1 onward; it is latched in the same cycle the frame starts.
    always_comb begin
        dado = BYTE_SINC;
        if (!inicia_quadro) begin
            case (indice_prox)
                2'd1:    dado = quadro[15:8];
                2'd2:    dado = quadro[7:0];
`ifdef TX_JOGO_CHECKSUM_EN
                2'd3:    dado = checksum(quadro);
`endif
                default: dado = BYTE_SINC;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ultimo    <= ULTIMO_RESET;
            quadro    <= '0;
            pendente  <= 1'b0;
            indice    <= '0;
            ocupado   <= 1'b0;
            fim_envio <= 1'b0;
        end else begin
            fim_envio <= 1'b0;
            pendente  <= pendente | forcar;
            if (inicia_quadro) begin
                // Starting a frame consumes any request, including one
                // arriving in this very cycle.
                quadro   <= status;
                ultimo   <= status;
                pendente <= 1'b0;
                indice   <= '0;
                ocupado  <= 1'b1;
            end else if (proximo_byte) begin
                indice <= indice_prox;
            end else if (ocupado && pronto) begin
                ocupado   <= 1'b0;
                fim_envio <= 1'b1;
            end
        end
    end

    uart_tx_byte #(
        .CICLOS_BIT(CICLOS_BIT)
    ) u_byte (
        .clock  (clock),
        .reset  (reset),
        .partida(partida),
        .dado   (dado),
        .tx     (tx),
        .pronto (pronto)
    );

endmodule

// File: tb/tb_tx_serial_jogo.sv
// ----------------------------------------------------------------------------
// tb_tx_serial_jogo
// Directed bench for tx_serial_jogo with CICLOS_BIT = 4. Frames are decoded
// from the serial line at bit centres and compared against hand-computed
// bytes; outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_tx_serial_jogo;

    localparam int C  = 4;
`ifdef TX_JOGO_CHECKSUM_EN
    localparam int NB = 4;
`else
    localparam int NB = 3;
`endif
    localparam int BYTE_CIC = 10 * C;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] macro_i, micro_i, estado_i;
    logic [1:0] rm_i, rj_i;
    logic       forcar;
    logic       tx, ocupado, fim_envio;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tx_serial_jogo #(.CICLOS_BIT(C)) dut (
        .clock               (clk),
        .reset               (reset),
        .uart_macro          (macro_i),
        .uart_micro          (micro_i),
        .uart_estado         (estado_i),
        .uart_resultado_macro(rm_i),
        .uart_resultado_jogo (rj_i),
        .forcar              (forcar),
        .tx                  (tx),
        .ocupado             (ocupado),
        .fim_envio           (fim_envio)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for the start bit, then decodes a whole frame and checks framing,
    // ocupado during the frame and the fim_envio pulse right after it.
    task automatic rx_frame(input string tag, input int exp_lat,
                            input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
        int w;
        int bad;
        int b;
        int r;
        logic [7:0] got [4];
        w   = 0;
        bad = 0;
        for (int k = 0; k < 4; k++) got[k] = 8'h00;
        @(negedge clk);
        while (tx !== 1'b0 && w < 200) begin
            w++;
            @(negedge clk);
        end
        check({tag, " latency"}, w, exp_lat);
        if (w >= 200) return;
        for (int off = 1; off <= NB * BYTE_CIC; off++) begin
            @(negedge clk);
            b = off / BYTE_CIC;
            r = off % BYTE_CIC;
            if (off == NB * BYTE_CIC) begin
                if (fim_envio !== 1'b1 || ocupado !== 1'b0) bad++;
            end else begin
                if (ocupado !== 1'b1 || fim_envio !== 1'b0) bad++;
                if (r == C / 2 && tx !== 1'b0) bad++;
                if (r == 9 * C + C / 2 && tx !== 1'b1) bad++;
                if (r >= C && r < 9 * C && (r % C) == C / 2)
                    got[b][(r / C) - 1] = tx;
            end
        end
        if (got[0] === 8'h00 && C / 2 < 1) bad++;
        check({tag, " byte0"}, got[0], e0);
        check({tag, " byte1"}, got[1], e1);
        check({tag, " byte2"}, got[2], e2);
`ifdef TX_JOGO_CHECKSUM_EN
        check({tag, " byte3"}, got[3], e3);
`else
        if (e3 === 8'hxx) bad++;
`endif
        check({tag, " framing"}, bad, 0);
    endtask

    task automatic idle_watch(input string tag, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || ocupado !== 1'b0 || fim_envio !== 1'b0) bad++;
        end
        check(tag, bad, 0);
    endtask

    initial begin
        int w;
        int bad;
        reset    = 1'b1;
        macro_i  = 4'h0;
        micro_i  = 4'h0;
        estado_i = 4'h0;
        rm_i     = 2'd0;
        rj_i     = 2'd0;
        forcar   = 1'b0;

        // 1. reset state, then first frame with S = 0
        repeat (3) @(negedge clk);
        check("reset tx", tx, 1'b1);
        check("reset ocupado", ocupado, 1'b0);
        check("reset fim_envio", fim_envio, 1'b0);
        check("reset ultimo", dut.ultimo, 16'hFFFF);
        reset = 1'b0;
        rx_frame("zero", 0, 8'hA5, 8'h00, 8'h00, 8'h00);
        check("zero ultimo", dut.ultimo, 16'h0000);
        idle_watch("zero idle", 60);

        // 2. status 3,7,5,2,1
        macro_i = 4'h3; micro_i = 4'h7; estado_i = 4'h5; rm_i = 2'd2; rj_i = 2'd1;
        rx_frame("s3759", 0, 8'hA5, 8'h37, 8'h59, 8'h6E);
        check("s3759 ultimo", dut.ultimo, 16'h3759);
        idle_watch("s3759 idle", 20);

        // 3. idle forcar resend; micro 7->8->9 during it, only 9 goes out
        forcar = 1'b1;
        fork
            rx_frame("resend", 0, 8'hA5, 8'h37, 8'h59, 8'h6E);
            begin
                @(negedge clk);
                forcar = 1'b0;
                repeat (30) @(negedge clk);
                micro_i = 4'h8;
                repeat (40) @(negedge clk);
                micro_i = 4'h9;
            end
        join
        rx_frame("latest", 0, 8'hA5, 8'h39, 8'h59, 8'h60);
        idle_watch("latest idle", 60);

        // 4. forcar pulses during a frame give exactly one extra frame
        forcar = 1'b1;
        fork
            rx_frame("force1", 0, 8'hA5, 8'h39, 8'h59, 8'h60);
            begin
                @(negedge clk);
                forcar = 1'b0;
                repeat (10) @(negedge clk);
                forcar = 1'b1;
                @(negedge clk);
                forcar = 1'b0;
                repeat (30) @(negedge clk);
                forcar = 1'b1;
                @(negedge clk);
                forcar = 1'b0;
            end
        join
        rx_frame("force2", 0, 8'hA5, 8'h39, 8'h59, 8'h60);
        idle_watch("force idle", 60);

        // forcar together with a change: a single frame
        micro_i = 4'hA;
        forcar  = 1'b1;
        fork
            rx_frame("both", 0, 8'hA5, 8'h3A, 8'h59, 8'h63);
            begin
                @(negedge clk);
                forcar = 1'b0;
            end
        join
        idle_watch("both idle", 60);

        // 5. reset during bit 3 of byte 1 (byte 1 = 0x34, bit 3 is 0)
        micro_i = 4'h4;
        w = 0;
        @(negedge clk);
        while (tx !== 1'b0 && w < 200) begin
            w++;
            @(negedge clk);
        end
        check("abort latency", w, 0);
        repeat (BYTE_CIC + 4 * C + 1) @(negedge clk);
        check("abort bit3 low", tx, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("abort tx", tx, 1'b1);
        check("abort ocupado", ocupado, 1'b0);
        check("abort fim_envio", fim_envio, 1'b0);
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (tx !== 1'b1 || ocupado !== 1'b0 || fim_envio !== 1'b0) bad++;
        end
        check("abort hold", bad, 0);
        reset = 1'b0;
        rx_frame("after abort", 0, 8'hA5, 8'h34, 8'h59, 8'h6D);
        idle_watch("after abort idle", 20);

        // 6. S = FFFF at reset release: silent until forcar
        reset   = 1'b1;
        macro_i = 4'hF; micro_i = 4'hF; estado_i = 4'hF; rm_i = 2'd3; rj_i = 2'd3;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idle_watch("ffff silent", 80);
        forcar = 1'b1;
        fork
            rx_frame("ffff forced", 0, 8'hA5, 8'hFF, 8'hFF, 8'h00);
            begin
                @(negedge clk);
                forcar = 1'b0;
            end
        join
        check("ffff ultimo", dut.ultimo, 16'hFFFF);
        idle_watch("ffff idle", 40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
